ps2_device_tx: RTL and testbench

//   Device-side PS/2 transmitter. It sends queued scan-code bytes as 11-bit PS/2 frames and

---
 rtl/ps2_device_tx_pkg.sv | 25 ++
 rtl/ps2_device_tx_fifo.sv | 65 ++++++
 rtl/ps2_device_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_device_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_device_tx_pkg.sv
// Shared PS/2 device-transmit definitions: FSM encoding, frame geometry and
// frame/parity helpers.
package ps2_device_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BIT_HI  = 3'd1,
    ST_BIT_LO  = 3'd2,
    ST_GAP     = 3'd3,
    ST_INHIBIT = 3'd4
  } ps2_state_e;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [3:0] PS2_STOP_IDX   = 4'(PS2_FRAME_BITS - 1);

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bit 0 goes on the wire first: start, d[0]..d[7], parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] build_frame(input logic [7:0] d);
    return {1'b1, odd_parity(d), d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_device_tx_fifo.sv
// Byte FIFO in front of the PS/2 transmitter. Flags are registered so that
// in_ready and the FSM start condition come straight from flops.
module ps2_device_tx_fifo #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam int            DEPTH    = 2 ** AW;
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: serialises queued bytes into 11-bit frames,
// driving both ps2_clk and ps2_data, and backs off while the host inhibits.
//
// state      | meaning
// ST_IDLE    | lines high, waiting for a byte and no inhibit
// ST_BIT_HI  | ps2_clk high half of the current bit, data presented
// ST_BIT_LO  | ps2_clk low half, data held; host samples on the falling edge
// ST_GAP     | both lines high for GAP_CYCLES after a frame or an abort
// ST_INHIBIT | host holds clock low; frame aborted, head byte kept for retry
module ps2_device_tx
  import ps2_device_tx_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int GAP_CYCLES = 64,
  parameter int FIFO_AW    = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       host_inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       tx_done
);

  localparam int            PW       = $clog2(CLK_DIV + GAP_CYCLES);
  localparam logic [PW-1:0] BIT_LOAD = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GAP_LOAD = PW'(GAP_CYCLES - 1);

  ps2_state_e state_q, state_d;
  logic [PW-1:0]             phase_q, phase_d;
  logic [3:0]                bit_q, bit_d;
  logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
  logic inh_meta_q, inh_s_q;
  logic ps2_clk_q, ps2_clk_d, ps2_data_q, ps2_data_d;
  logic busy_q, busy_d, tx_done_q, tx_done_d;

  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [FIFO_AW:0] fifo_count;
  logic             phase_done, in_bit, is_stop, abort, frame_end, start_ok;

  ps2_device_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (in_valid),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inh_meta_q <= 1'b0;
      inh_s_q    <= 1'b0;
    end else begin
      inh_meta_q <= host_inhibit;
      inh_s_q    <= inh_meta_q;
    end
  end

  assign phase_done = (phase_q == '0);
  assign in_bit     = (state_q == ST_BIT_HI) || (state_q == ST_BIT_LO);
  assign is_stop    = (bit_q == PS2_STOP_IDX);
  // Once the stop bit is on the wire the frame is finished regardless of inhibit.
  assign abort      = in_bit && !is_stop && inh_s_q;
  assign frame_end  = (state_q == ST_BIT_LO) && is_stop && phase_done;
  assign start_ok   = !fifo_empty && !inh_s_q;
  assign fifo_pop   = frame_end && (fifo_count != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_BIT_HI;
          bit_d   = '0;
          shift_d = build_frame(fifo_rdata);
        end
      end
      ST_BIT_HI: begin
        if (abort)           state_d = ST_INHIBIT;
        else if (phase_done) state_d = ST_BIT_LO;
      end
      ST_BIT_LO: begin
        if (abort) begin
          state_d = ST_INHIBIT;
        end else if (phase_done) begin
          if (is_stop) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_BIT_HI;
            bit_d   = bit_q + 4'd1;
            shift_d = {1'b1, shift_q[PS2_FRAME_BITS-1:1]};
          end
        end
      end
      ST_GAP: begin
        // Chain straight into the next queued frame so busy never drops between frames.
        if (phase_done) begin
          if (start_ok) begin
            state_d = ST_BIT_HI;
            bit_d   = '0;
            shift_d = build_frame(fifo_rdata);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_INHIBIT: begin
        if (!inh_s_q) state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q || (state_q == ST_BIT_LO && state_d == ST_BIT_HI)) begin
      case (state_d)
        ST_BIT_HI, ST_BIT_LO: phase_d = BIT_LOAD;
        ST_GAP:               phase_d = GAP_LOAD;
        default:              phase_d = '0;
      endcase
    end else if (!phase_done) begin
      phase_d = phase_q - 1'b1;
    end
  end

  always_comb begin
    ps2_clk_d  = 1'b1;
    ps2_data_d = 1'b1;
    case (state_q)
      ST_BIT_HI: ps2_data_d = shift_q[0];
      ST_BIT_LO: begin
        ps2_clk_d  = 1'b0;
        ps2_data_d = shift_q[0];
      end
      default: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
      end
    endcase
    if (abort) begin
      ps2_clk_d  = 1'b1;
      ps2_data_d = 1'b1;
    end
    tx_done_d = frame_end;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign in_ready = !fifo_full;
  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx: a line-level PS/2 receiver model decodes
// frames and checks them against a queue of bytes accepted at the input.
module tb_ps2_device_tx;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int FIFO_AW    = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       host_inhibit = 1'b0;
  logic       in_ready, ps2_clk, ps2_data, busy, tx_done;

  ps2_device_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .FIFO_AW(FIFO_AW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .host_inhibit (host_inhibit),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  int          idx = 0;
  logic [10:0] rx_bits = '0;
  logic [10:0] last_frame = '0;
  int          frames_rx = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int          last_len = 0, hi_run = 0, clk_hi_run = 0, last_gap = 0, accept_cyc = 0;
  logic        prev_clk = 1'b1, prev_data = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic p;
    p = 1'b1;
    for (int i = 0; i < 8; i++) p = p ^ b[i];
    return {1'b1, p, b, 1'b0};
  endfunction

  // Receiver model: samples data on each ps2_clk fall, closes the frame on the
  // rise after the 11th bit, and drops partial frames on a long clock-high stretch.
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      idx = 0; hi_run = 0; clk_hi_run = 0; prev_clk = 1'b1; prev_data = 1'b1;
    end else begin
      if (tx_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (idx == 0 && prev_data && !ps2_data && ps2_clk) begin
        start_cyc = cyc;
        last_gap  = hi_run;
      end
      if (prev_clk && !ps2_clk) begin
        if (idx < 11) rx_bits[idx] = ps2_data;
        idx++;
      end else if (!prev_clk && ps2_clk && idx == 11) begin
        frames_rx++;
        last_frame = rx_bits;
        last_len   = cyc - start_cyc;
        check("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("rx_frame", rx_bits, frame_of(exp_q.pop_front()));
        idx = 0;
      end
      clk_hi_run = ps2_clk ? clk_hi_run + 1 : 0;
      if (clk_hi_run > 2 * CLK_DIV && idx != 0) idx = 0;
      hi_run    = (ps2_clk && ps2_data) ? hi_run + 1 : 0;
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    exp_q.push_back(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (frames_rx < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, frames_rx, target);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_idx(input int target, input logic need_hi, input string tag);
    int n = 0;
    while (!(idx == target && (!need_hi || ps2_clk)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, idx, target);
  endtask

  initial begin
    int   base, base_done, n;
    logic flag;

    repeat (3) @(negedge clk);
    check("rst_clk", ps2_clk, 1'b1);
    check("rst_data", ps2_data, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: exact line bits and frame length
    push_byte(8'h1C);
    wait_frames(1, 400, "t1_frame");
    check("t1_bits", last_frame, 11'h438);
    check("t1_len", last_len, 22 * CLK_DIV);
    wait_idle("t1_idle");
    check("t1_done", done_cnt, 1);

    // Parity extremes, each followed by an idle-high stretch
    push_byte(8'h00);
    wait_frames(2, 400, "t2_frame00");
    check("t2_par00", last_frame[9], 1'b1);
    wait_idle("t2_idle00");
    repeat (2) @(negedge clk);
    check("t2_gap00", hi_run >= GAP_CYCLES, 1'b1);
    push_byte(8'hFF);
    wait_frames(3, 400, "t2_frameff");
    check("t2_parff", last_frame[9], 1'b1);
    wait_idle("t2_idleff");
    repeat (2) @(negedge clk);
    check("t2_gapff", hi_run >= GAP_CYCLES, 1'b1);

    // Back-to-back: exact gap, busy held between frames
    base = frames_rx;
    push_byte(8'hF0);
    push_byte(8'h1C);
    flag = 1'b0;
    n = 0;
    while (frames_rx < base + 2 && n < 800) begin
      @(negedge clk);
      n++;
      if (frames_rx == base + 1 && !busy) flag = 1'b1;
    end
    check("t3_frames", frames_rx, base + 2);
    check("t3_gap", last_gap, GAP_CYCLES);
    check("t3_busy_held", flag, 1'b0);
    wait_idle("t3_idle");

    // Fill the FIFO: 9th byte goes in the cycle after the first pop
    base = frames_rx;
    for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
    check("t4_full", in_ready, 1'b0);
    push_byte(8'h38);
    check("t4_b9_accept", accept_cyc, done_cyc + 1);
    wait_frames(base + 9, 9 * 150, "t4_frames");
    wait_idle("t4_idle");

    // Inhibit during bit 5 aborts; release retransmits the whole byte
    base = frames_rx;
    base_done = done_cnt;
    push_byte(8'h5A);
    wait_idx(6, 1'b0, "t5_reach_bit5");
    host_inhibit = 1'b1;
    n = 0;
    while (!(ps2_clk && ps2_data) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_release_lat", n <= 3, 1'b1);
    flag = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(ps2_clk && ps2_data)) flag = 1'b0;
    end
    check("t5_lines_high", flag, 1'b1);
    check("t5_no_done", done_cnt, base_done);
    check("t5_busy", busy, 1'b1);
    host_inhibit = 1'b0;
    wait_frames(base + 1, 400, "t5_retx");
    check("t5_done", done_cnt, base_done + 1);
    wait_idle("t5_idle");

    // Inhibit during the stop bit: frame still completes
    push_byte(8'h33);
    wait_idx(10, 1'b1, "t5_reach_stop");
    host_inhibit = 1'b1;
    wait_frames(base + 2, 100, "t5_stop_frame");
    check("t5_stop_done", done_cnt, base_done + 2);
    host_inhibit = 1'b0;
    wait_idle("t5_stop_idle");

    // Reset mid-frame with bytes queued: everything discarded
    base = frames_rx;
    base_done = done_cnt;
    push_byte(8'hA1);
    push_byte(8'hB2);
    push_byte(8'hC3);
    wait_idx(3, 1'b0, "t6_reach_bit3");
    resetn = 1'b0;
    #1;
    check("t6_clk", ps2_clk, 1'b1);
    check("t6_data", ps2_data, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_ready", in_ready, 1'b1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (300) @(negedge clk);
    check("t6_no_frame", frames_rx, base);
    check("t6_no_done", done_cnt, base_done);
    check("t6_idle", busy, 1'b0);

    check("sb_drained", exp_q.size(), 0);
    check("done_vs_frames", done_cnt, frames_rx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
